// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, fixed-latency memory between the fetch port and the data port.
// On contention the two ports take turns, and only one access is in flight at a time.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CW = $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LAT - 1);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t        state, state_n;
  logic          last_dm;
  logic          kill;
  logic          en_q;
  logic [CW-1:0] cnt;
  logic          grant_if, grant_dm;
  logic          kill_now;

  assign mem_en = en_q;

  // Arbitration, ack generation and read-data pass-through.
  // A flush that lands in the ack cycle itself also suppresses that ack.
  always_comb begin
    state_n  = state;
    grant_if = 1'b0;
    grant_dm = 1'b0;
    kill_now = kill | if_flush;
    if_ack   = 1'b0;
    dm_ack   = 1'b0;
    if_rdata = '0;
    dm_rdata = '0;
    case (state)
      IDLE: begin
        if (dm_req && (!if_req || !last_dm)) begin
          grant_dm = 1'b1;
          state_n  = BUSY_D;
        end else if (if_req) begin
          grant_if = 1'b1;
          state_n  = BUSY_I;
        end
      end
      BUSY_I: begin
        if (cnt == '0) begin
          state_n = IDLE;
          if (!kill_now && !rst) begin
            if_ack   = 1'b1;
            if_rdata = mem_rdata;
          end
        end
      end
      BUSY_D: begin
        if (cnt == '0) begin
          state_n = IDLE;
          if (!rst) begin
            dm_ack = 1'b1;
            if (!mem_we) dm_rdata = mem_rdata;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // The winner's request is latched at the grant edge and held for the whole access.
  // The latched values stay on mem_* until the next grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last_dm   <= 1'b0;
      kill      <= 1'b0;
      en_q      <= 1'b0;
      cnt       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state <= state_n;
      en_q  <= grant_if | grant_dm;
      if (grant_dm) begin
        mem_addr  <= dm_addr;
        mem_we    <= dm_we;
        mem_wdata <= dm_wdata;
        last_dm   <= 1'b1;
        cnt       <= CNT_INIT;
      end else if (grant_if) begin
        mem_addr  <= if_addr;
        mem_we    <= 1'b0;
        mem_wdata <= '0;
        last_dm   <= 1'b0;
        cnt       <= CNT_INIT;
      end else if (state != IDLE && cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
      if (state == BUSY_I && cnt == '0) kill <= 1'b0;
      else if (state == BUSY_I && if_flush) kill <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a MEM_LAT=2 instance with a behavioural memory,
// plus a MEM_LAT=1 instance for the same-cycle mem_en/ack case.
module tb_mem_port_arbiter;

  typedef struct packed {
    logic        dm;
    logic [31:0] data;
    logic [31:0] cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  ev_t exp_q[$];
  ev_t obs_q[$];
  ev_t exp_b[$];
  ev_t obs_b[$];
  ev_t mon_e;

  // Instance A, MEM_LAT = 2
  logic        if_req, if_flush, if_ack, dm_req, dm_we, dm_ack, mem_en, mem_we;
  logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem_a [0:255];

  // Instance B, MEM_LAT = 1
  logic        if_req_b, if_flush_b, if_ack_b, dm_req_b, dm_we_b, dm_ack_b, mem_en_b, mem_we_b;
  logic [31:0] if_addr_b, if_rdata_b, dm_addr_b, dm_wdata_b, dm_rdata_b;
  logic [31:0] mem_addr_b, mem_wdata_b, mem_rdata_b;
  logic [31:0] mem_b [0:255];

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut_b (
    .clk(clk), .rst(rst),
    .if_req(if_req_b), .if_addr(if_addr_b), .if_flush(if_flush_b), .if_ack(if_ack_b),
    .if_rdata(if_rdata_b),
    .dm_req(dm_req_b), .dm_we(dm_we_b), .dm_addr(dm_addr_b), .dm_wdata(dm_wdata_b),
    .dm_ack(dm_ack_b), .dm_rdata(dm_rdata_b),
    .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .mem_rdata(mem_rdata_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural memories: reads are combinational on the held address, writes land at mem_en.
  assign mem_rdata   = mem_a[mem_addr[9:2]];
  assign mem_rdata_b = mem_b[mem_addr_b[9:2]];
  always @(posedge clk) if (mem_en && mem_we) mem_a[mem_addr[9:2]] = mem_wdata;
  always @(posedge clk) if (mem_en_b && mem_we_b) mem_b[mem_addr_b[9:2]] = mem_wdata_b;

  // Ack monitor: records every ack with its data and cycle number.
  always @(negedge clk) begin
    if (if_ack) begin mon_e = '{dm: 1'b0, data: if_rdata, cyc: cyc}; obs_q.push_back(mon_e); end
    if (dm_ack) begin mon_e = '{dm: 1'b1, data: dm_rdata, cyc: cyc}; obs_q.push_back(mon_e); end
    if (if_ack_b) begin mon_e = '{dm: 1'b0, data: if_rdata_b, cyc: cyc}; obs_b.push_back(mon_e); end
    if (dm_ack_b) begin mon_e = '{dm: 1'b1, data: dm_rdata_b, cyc: cyc}; obs_b.push_back(mon_e); end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_obs(input int limit, output bit got);
    got = 1'b0;
    for (int i = 0; i <= limit; i++) begin
      if (obs_q.size() != 0) begin
        got = 1'b1;
        return;
      end
      step();
    end
  endtask

  task automatic push_exp(input logic dm, input logic [31:0] data, input int at);
    ev_t e;
    e = '{dm: dm, data: data, cyc: at};
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    n_checks++;
    if ({mem_en, mem_we, if_ack, dm_ack} !== 4'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 ||
        if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got en=%b we=%b ia=%b da=%b addr=%h wd=%h ir=%h dr=%h, required all 0",
               mem_en, mem_we, if_ack, dm_ack, mem_addr, mem_wdata, if_rdata, dm_rdata);
    end
    n_checks++;
    if ({mem_en_b, dm_ack_b, if_ack_b} !== 3'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs_b: got en=%b da=%b ia=%b, required 0", mem_en_b, dm_ack_b, if_ack_b);
    end
  endtask

  task automatic test_arbitration();
    bit  got;
    ev_t o, e;
    if_req  = 1'b1; if_addr = 32'h44;
    dm_req  = 1'b1; dm_we   = 1'b0; dm_addr = 32'h100;
    step();
    rst = 1'b0;
    push_exp(1'b1, 32'h1000_0040, cyc + 2);
    push_exp(1'b0, 32'h1000_0011, cyc + 5);
    push_exp(1'b1, 32'h1000_0040, cyc + 8);
    push_exp(1'b0, 32'h1000_0011, cyc + 11);
    for (int k = 0; k < 4; k++) begin
      wait_obs(10, got);
      n_checks++;
      if (!got) begin
        n_fail++;
        $display("[TB] FAIL arb_ack%0d: no ack within 10 cycles, required one", k);
      end else begin
        o = obs_q.pop_front();
        e = exp_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("[TB] FAIL arb_ack%0d: got dm=%0b data=%h cyc=%0d, required dm=%0b data=%h cyc=%0d",
                   k, o.dm, o.data, o.cyc, e.dm, e.data, e.cyc);
        end
      end
      if (k == 2) dm_req = 1'b0;
      if (k == 3) if_req = 1'b0;
      step();
    end
  endtask

  task automatic test_fetch();
    bit  got;
    ev_t o, e;
    int  c0;
    step();
    c0 = cyc;
    if_req = 1'b1; if_addr = 32'h40;
    push_exp(1'b0, 32'h0050_0093, c0 + 2);
    step();
    n_checks++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h40) begin
      n_fail++;
      $display("[TB] FAIL fetch_issue: got en=%b we=%b addr=%h, required en=1 we=0 addr=00000040",
               mem_en, mem_we, mem_addr);
    end
    wait_obs(10, got);
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("[TB] FAIL fetch_ack: no ack within 10 cycles, required one");
    end else begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      if (o !== e) begin
        n_fail++;
        $display("[TB] FAIL fetch_ack: got dm=%0b data=%h cyc=%0d, required dm=%0b data=%h cyc=%0d",
                 o.dm, o.data, o.cyc, e.dm, e.data, e.cyc);
      end
    end
    if_req = 1'b0;
    step();
    n_checks++;
    if (mem_en !== 1'b0 || if_ack !== 1'b0 || if_rdata !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL fetch_idle: got en=%b ack=%b rdata=%h, required 0 0 00000000",
               mem_en, if_ack, if_rdata);
    end
  endtask

  task automatic test_store_load();
    bit  got;
    ev_t o, e;
    int  c0;
    c0 = cyc;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h200; dm_wdata = 32'hDEAD_BEEF;
    push_exp(1'b1, 32'h0, c0 + 2);
    step();
    n_checks++;
    if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h200 || mem_wdata !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("[TB] FAIL store_issue: got en=%b we=%b addr=%h wd=%h, required 1 1 00000200 deadbeef",
               mem_en, mem_we, mem_addr, mem_wdata);
    end
    dm_addr = 32'h0; dm_wdata = 32'h0;
    step();
    n_checks++;
    if (mem_en !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 32'h200 || mem_wdata !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("[TB] FAIL store_hold: got en=%b we=%b addr=%h wd=%h, required 0 1 00000200 deadbeef",
               mem_en, mem_we, mem_addr, mem_wdata);
    end
    wait_obs(10, got);
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("[TB] FAIL store_ack: no ack within 10 cycles, required one");
    end else begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      if (o !== e) begin
        n_fail++;
        $display("[TB] FAIL store_ack: got dm=%0b data=%h cyc=%0d, required dm=%0b data=%h cyc=%0d",
                 o.dm, o.data, o.cyc, e.dm, e.data, e.cyc);
      end
    end
    dm_req = 1'b0;
    step();
    c0 = cyc;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200;
    push_exp(1'b1, 32'hDEAD_BEEF, c0 + 2);
    wait_obs(10, got);
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("[TB] FAIL load_back: no ack within 10 cycles, required one");
    end else begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      if (o !== e) begin
        n_fail++;
        $display("[TB] FAIL load_back: got dm=%0b data=%h cyc=%0d, required dm=%0b data=%h cyc=%0d",
                 o.dm, o.data, o.cyc, e.dm, e.data, e.cyc);
      end
    end
    dm_req = 1'b0;
    step();
  endtask

  task automatic test_flush();
    bit  got;
    ev_t o, e;
    int  c0;
    c0 = cyc;
    if_req = 1'b1; if_addr = 32'h48;
    step();
    if_flush = 1'b1; if_addr = 32'h80;
    step();
    if_flush = 1'b0;
    n_checks++;
    if (if_ack !== 1'b0 || obs_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL flush_kill: got if_ack=%b recorded_acks=%0d, required 0 and 0",
               if_ack, obs_q.size());
    end
    push_exp(1'b0, 32'h1000_0020, c0 + 5);
    wait_obs(10, got);
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("[TB] FAIL flush_refetch: no ack within 10 cycles, required one");
    end else begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      if (o !== e) begin
        n_fail++;
        $display("[TB] FAIL flush_refetch: got dm=%0b data=%h cyc=%0d, required dm=%0b data=%h cyc=%0d",
                 o.dm, o.data, o.cyc, e.dm, e.data, e.cyc);
      end
    end
    if_req = 1'b0;
    step();
  endtask

  task automatic test_reset_midaccess();
    bit  got;
    ev_t o, e;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h104;
    step();
    rst = 1'b1;
    step();
    n_checks++;
    if ({mem_en, mem_we, if_ack, dm_ack} !== 4'b0 || mem_addr !== 32'h0 || dm_rdata !== 32'h0 ||
        obs_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL rst_mid: got en=%b we=%b ia=%b da=%b addr=%h dr=%h acks=%0d, required all 0",
               mem_en, mem_we, if_ack, dm_ack, mem_addr, dm_rdata, obs_q.size());
    end
    rst = 1'b0;
    push_exp(1'b1, 32'h1000_0041, cyc + 2);
    wait_obs(10, got);
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("[TB] FAIL rst_regrant: no ack within 10 cycles, required one");
    end else begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      if (o !== e) begin
        n_fail++;
        $display("[TB] FAIL rst_regrant: got dm=%0b data=%h cyc=%0d, required dm=%0b data=%h cyc=%0d",
                 o.dm, o.data, o.cyc, e.dm, e.data, e.cyc);
      end
    end
    dm_req = 1'b0;
    step();
  endtask

  task automatic test_lat1();
    ev_t o, e;
    int  c0;
    c0 = cyc;
    dm_req_b = 1'b1; dm_we_b = 1'b0; dm_addr_b = 32'h10;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k % 2 == 1) begin
        e = '{dm: 1'b1, data: 32'h1000_0004, cyc: c0 + k};
        exp_b.push_back(e);
      end
      n_checks++;
      if (dm_ack_b !== (k % 2 == 1) || mem_en_b !== (k % 2 == 1)) begin
        n_fail++;
        $display("[TB] FAIL lat1_cycle%0d: got ack=%b en=%b, required ack=%b en=%b",
                 k, dm_ack_b, mem_en_b, (k % 2 == 1), (k % 2 == 1));
      end
      if (k == 7) dm_req_b = 1'b0;
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (obs_b.size() == 0 || exp_b.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL lat1_ack%0d: got %0d recorded acks, required 4", k, k);
      end else begin
        o = obs_b.pop_front();
        e = exp_b.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("[TB] FAIL lat1_ack%0d: got dm=%0b data=%h cyc=%0d, required dm=%0b data=%h cyc=%0d",
                   k, o.dm, o.data, o.cyc, e.dm, e.data, e.cyc);
        end
      end
    end
  endtask

  task automatic test_drain();
    repeat (4) step();
    n_checks++;
    if (obs_q.size() != 0 || exp_q.size() != 0 || obs_b.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL drain: got leftover obs=%0d exp=%0d obs_b=%0d, required 0 0 0",
               obs_q.size(), exp_q.size(), obs_b.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 32'h1000_0000 + i;
      mem_b[i] = 32'h1000_0000 + i;
    end
    mem_a[16] = 32'h0050_0093;
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    if_req_b = 1'b0; if_addr_b = '0; if_flush_b = 1'b0;
    dm_req_b = 1'b0; dm_we_b = 1'b0; dm_addr_b = '0; dm_wdata_b = '0;

    test_reset();
    test_arbitration();
    test_fetch();
    test_store_load();
    test_flush();
    test_reset_midaccess();
    test_lat1();
    test_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
